// File: rtl/i2s_receiver_pkg.sv
// i2s_receiver_pkg: shared defaults and FSM encoding for the I2S receiver
package i2s_receiver_pkg;
    localparam int DEF_WIDTH     = 16;
    localparam int DEF_SLOT_BITS = 16;
    typedef enum logic {ST_HUNT = 1'b0, ST_RUN = 1'b1} state_e;
endpackage

// File: rtl/i2s_receiver_if.sv
// i2s_receiver_if: I2S pins plus decoded audio outputs of the receiver
interface i2s_receiver_if
    import i2s_receiver_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             i2s_bclk;
    logic             i2s_lrclk;
    logic             i2s_din;
    logic [WIDTH-1:0] audio_left;
    logic [WIDTH-1:0] audio_right;
    logic             sample_valid;
    logic             frame_err;
    logic             locked;
    modport master (
        output i2s_bclk, i2s_lrclk, i2s_din,
        input  audio_left, audio_right, sample_valid, frame_err, locked
    );
    modport slave (
        input  i2s_bclk, i2s_lrclk, i2s_din,
        output audio_left, audio_right, sample_valid, frame_err, locked
    );
endinterface

// File: rtl/i2s_receiver_pin_sync.sv
// i2s_pin_sync: 2-flop synchroniser; with DETECT a history flop turns it into a rise detector
module i2s_pin_sync #(
    parameter bit DETECT = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic q
);
    logic [1:0] stage_q, stage_d;
    always_comb stage_d = {stage_q[0], pin};
    always_ff @(posedge clk) begin
        if (rst) stage_q <= '0;
        else     stage_q <= stage_d;
    end
    if (DETECT) begin : g_det
        logic hist_q, hist_d;
        always_comb hist_d = stage_q[1];
        always_ff @(posedge clk) begin
            if (rst) hist_q <= 1'b0;
            else     hist_q <= hist_d;
        end
        assign q = stage_q[1] & ~hist_q;
    end else begin : g_lvl
        assign q = stage_q[1];
    end
endmodule

// File: rtl/i2s_receiver.sv
// i2s_receiver: oversampling Philips I2S deserialiser presenting stereo pairs with a strobe
module i2s_receiver
    import i2s_receiver_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int SLOT_BITS = DEF_SLOT_BITS
) (
    input logic           sysclk,
    input logic           reset,
    i2s_receiver_if.slave bus
);
    localparam int CW = $clog2(SLOT_BITS + 2);
    logic bclk_rise, lr_s, din_s;
    i2s_pin_sync #(.DETECT(1'b1)) u_bclk (.clk(sysclk), .rst(reset), .pin(bus.i2s_bclk), .q(bclk_rise));
    i2s_pin_sync #(.DETECT(1'b0)) u_lr (.clk(sysclk), .rst(reset), .pin(bus.i2s_lrclk), .q(lr_s));
    i2s_pin_sync #(.DETECT(1'b0)) u_din (.clk(sysclk), .rst(reset), .pin(bus.i2s_din), .q(din_s));
    state_e           state_q, state_d;
    logic             lr_prev_q, lr_prev_d, lr_valid_q, lr_valid_d;
    logic             sample_valid_q, sample_valid_d, frame_err_q, frame_err_d;
    logic [WIDTH-1:0] shreg_q, shreg_d, hold_left_q, hold_left_d;
    logic [WIDTH-1:0] audio_left_q, audio_left_d, audio_right_q, audio_right_d, word;
    logic [CW-1:0]    bitcnt_q, bitcnt_d, cnt_inc;
    always_comb begin
        state_d        = state_q;
        lr_prev_d      = lr_prev_q;
        lr_valid_d     = lr_valid_q;
        shreg_d        = shreg_q;
        bitcnt_d       = bitcnt_q;
        hold_left_d    = hold_left_q;
        audio_left_d   = audio_left_q;
        audio_right_d  = audio_right_q;
        sample_valid_d = 1'b0;
        frame_err_d    = 1'b0;
        word           = shreg_q;
        // bits land by position so extra bits fall off and short words stay zero-padded
        for (int i = 0; i < WIDTH; i++)
            if (din_s && bitcnt_q == CW'(WIDTH - 1 - i)) word[i] = 1'b1;
        cnt_inc = (bitcnt_q == CW'(SLOT_BITS + 1)) ? bitcnt_q : bitcnt_q + CW'(1);
        if (bclk_rise) begin
            lr_prev_d  = lr_s;
            lr_valid_d = 1'b1;
            if (state_q == ST_HUNT) begin
                if (lr_valid_q && lr_s != lr_prev_q) state_d = ST_RUN;
            end else if (lr_s != lr_prev_q) begin
                frame_err_d = cnt_inc != CW'(SLOT_BITS);
                if (!lr_prev_q) hold_left_d = word;
                else begin
                    audio_left_d   = hold_left_q;
                    audio_right_d  = word;
                    sample_valid_d = 1'b1;
                end
                shreg_d  = '0;
                bitcnt_d = '0;
            end else begin
                shreg_d  = word;
                bitcnt_d = cnt_inc;
            end
        end
    end
    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q        <= ST_HUNT;
            lr_prev_q      <= 1'b0;
            lr_valid_q     <= 1'b0;
            shreg_q        <= '0;
            bitcnt_q       <= '0;
            hold_left_q    <= '0;
            audio_left_q   <= '0;
            audio_right_q  <= '0;
            sample_valid_q <= 1'b0;
            frame_err_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            lr_prev_q      <= lr_prev_d;
            lr_valid_q     <= lr_valid_d;
            shreg_q        <= shreg_d;
            bitcnt_q       <= bitcnt_d;
            hold_left_q    <= hold_left_d;
            audio_left_q   <= audio_left_d;
            audio_right_q  <= audio_right_d;
            sample_valid_q <= sample_valid_d;
            frame_err_q    <= frame_err_d;
        end
    end
    assign bus.audio_left   = audio_left_q;
    assign bus.audio_right  = audio_right_q;
    assign bus.sample_valid = sample_valid_q;
    assign bus.frame_err    = frame_err_q;
    assign bus.locked       = state_q == ST_RUN;
endmodule

// File: tb/tb_i2s_receiver.sv
// tb_i2s_receiver: directed I2S transmitter driving the receiver, with captured pairs checked against hand values
module tb_i2s_receiver;
    localparam int NSWEEP = 200;
    logic sysclk = 1'b0;
    logic reset  = 1'b1;
    int   total  = 0;
    int   bad    = 0;
    int   half   = 400;
    int   ferr   = 0;
    logic pend   = 1'b0;
    logic skip   = 1'b0;
    logic cur_ch = 1'b1;
    logic [15:0] cl[$];
    logic [15:0] cr[$];
    logic [15:0] exp_l[NSWEEP];
    logic [15:0] exp_r[NSWEEP];

    i2s_receiver_if #(.WIDTH(16)) bus ();
    i2s_receiver #(.WIDTH(16), .SLOT_BITS(16)) dut (.sysclk(sysclk), .reset(reset), .bus(bus));

    always #50 sysclk = ~sysclk;

    always @(negedge sysclk) begin
        if (bus.sample_valid) begin
            cl.push_back(bus.audio_left);
            cr.push_back(bus.audio_right);
        end
        if (bus.frame_err) ferr++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tx_bit(input logic lr, input logic d);
        bus.i2s_bclk  = 1'b0;
        bus.i2s_lrclk = lr;
        bus.i2s_din   = d;
        #half;
        bus.i2s_bclk = 1'b1;
        #half;
    endtask

    // period 0 of a slot carries the previous word's LSB (one-bit I2S delay)
    task automatic send_bits(input logic ch, input logic [31:0] w, input int n, input int lo, input int hi);
        for (int i = lo; i < hi; i++)
            if (!(i == 0 && skip)) tx_bit(ch, i == 0 ? pend : w[n-i]);
        skip   = 1'b0;
        cur_ch = ch;
        if (hi == n) pend = w[0];
    endtask

    task automatic send_word(input logic ch, input logic [31:0] w, input int n);
        send_bits(ch, w, n, 0, n);
    endtask

    task automatic close_stream();
        tx_bit(~cur_ch, pend);
        skip = 1'b1;
        repeat (8) @(negedge sysclk);
    endtask

    task automatic phase_jump();
        int t, target, g;
        t      = int'($time % 100);
        target = $urandom_range(0, 1) ? $urandom_range(5, 45) : $urandom_range(55, 95);
        g      = (target - t + 100) % 100;
        if (g > 0) #g;
    endtask

    initial begin
        int f0;
        bus.i2s_bclk  = 1'b1;
        bus.i2s_lrclk = 1'b1;
        bus.i2s_din   = 1'b0;
        repeat (4) @(negedge sysclk);
        reset = 1'b0;
        repeat (2) @(negedge sysclk);
        check("rst_left", 32'(bus.audio_left), 32'h0);
        check("rst_right", 32'(bus.audio_right), 32'h0);
        check("rst_valid", 32'(bus.sample_valid), 32'h0);
        check("rst_ferr", 32'(bus.frame_err), 32'h0);
        check("rst_locked", 32'(bus.locked), 32'h0);
        #13;

        // basic pair, BCLK = sysclk/8, preceded by a right-channel preamble for locking
        send_word(1'b1, 32'h0, 16);
        check("hunt_unlocked", 32'(bus.locked), 32'h0);
        for (int k = 0; k < 3; k++) begin
            send_word(1'b0, 32'hA55A, 16);
            send_word(1'b1, 32'h1234, 16);
        end
        close_stream();
        check("basic_locked", 32'(bus.locked), 32'h1);
        check("basic_count", 32'(cl.size()), 32'd3);
        for (int k = 0; k < 3; k++) begin
            check("basic_left", 32'(cl[k]), 32'hA55A);
            check("basic_right", 32'(cr[k]), 32'h1234);
        end
        check("basic_ferr", 32'(ferr), 32'd0);

        // one-bit delay alignment
        cl.delete(); cr.delete();
        send_word(1'b0, 32'h8001, 16);
        send_word(1'b1, 32'h0001, 16);
        close_stream();
        check("delay_count", 32'(cl.size()), 32'd1);
        check("delay_left", 32'(cl[0]), 32'h8001);
        check("delay_right", 32'(cr[0]), 32'h0001);
        check("delay_ferr", 32'(ferr), 32'd0);

        // 18-bit slots: top 16 bits kept, every boundary flagged
        cl.delete(); cr.delete(); f0 = ferr;
        for (int k = 0; k < 2; k++) begin
            send_word(1'b0, 32'h3FFFB, 18);
            send_word(1'b1, 32'h3FFFB, 18);
        end
        close_stream();
        check("long_count", 32'(cl.size()), 32'd2);
        check("long_left", 32'(cl[1]), 32'hFFFE);
        check("long_right", 32'(cr[1]), 32'hFFFE);
        check("long_ferr", 32'(ferr - f0), 32'd4);

        // 14-bit slots: zero-padded LSBs
        cl.delete(); cr.delete(); f0 = ferr;
        send_word(1'b0, 32'h3FFF, 14);
        send_word(1'b1, 32'h3FFF, 14);
        close_stream();
        check("short_count", 32'(cl.size()), 32'd1);
        check("short_left", 32'(cl[0]), 32'hFFFC);
        check("short_right", 32'(cr[0]), 32'hFFFC);
        check("short_ferr", 32'(ferr - f0), 32'd2);

        // reset during bit 7 of a left word; first right after relock carries left = 0
        cl.delete(); cr.delete(); f0 = ferr;
        send_bits(1'b0, 32'h9999, 16, 0, 7);
        @(negedge sysclk) reset = 1'b1;
        @(negedge sysclk) reset = 1'b0;
        @(negedge sysclk);
        check("mid_rst_left", 32'(bus.audio_left), 32'h0);
        check("mid_rst_right", 32'(bus.audio_right), 32'h0);
        check("mid_rst_locked", 32'(bus.locked), 32'h0);
        send_bits(1'b0, 32'h9999, 16, 7, 16);
        check("mid_rst_nopulse", 32'(cl.size()), 32'd0);
        send_word(1'b1, 32'h5A5A, 16);
        send_word(1'b0, 32'hC3C3, 16);
        send_word(1'b1, 32'h3C3C, 16);
        close_stream();
        check("relock_count", 32'(cl.size()), 32'd2);
        check("relock_first_left", 32'(cl[0]), 32'h0);
        check("relock_first_right", 32'(cr[0]), 32'h5A5A);
        check("relock_left", 32'(cl[1]), 32'hC3C3);
        check("relock_right", 32'(cr[1]), 32'h3C3C);
        check("relock_ferr", 32'(ferr - f0), 32'd0);

        // BCLK = sysclk/4 with the phase moved between pairs
        cl.delete(); cr.delete(); f0 = ferr;
        half = 200;
        for (int k = 0; k < NSWEEP; k++) begin
            exp_l[k] = 16'($urandom);
            exp_r[k] = 16'($urandom);
            phase_jump();
            send_word(1'b0, 32'(exp_l[k]), 16);
            send_word(1'b1, 32'(exp_r[k]), 16);
        end
        close_stream();
        check("sweep_count", 32'(cl.size()), 32'(NSWEEP));
        for (int k = 0; k < NSWEEP; k++) begin
            check("sweep_left", 32'(cl[k]), 32'(exp_l[k]));
            check("sweep_right", 32'(cr[k]), 32'(exp_r[k]));
        end
        check("sweep_ferr", 32'(ferr - f0), 32'd0);

        // stopped BCLK: nothing moves
        repeat (50) @(negedge sysclk);
        check("idle_count", 32'(cl.size()), 32'(NSWEEP));
        check("idle_right", 32'(bus.audio_right), 32'(exp_r[NSWEEP-1]));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
